// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci generator slice: term width, buffer geometry
// and the ALU flag encodings, so the upstream carry decode and the buffer agree.
package fib_pkg;

    localparam int DW    = 6;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef enum logic [1:0] {
        FLAG_N  = 2'b00,
        FLAG_OC = 2'b01,
        FLAG_B  = 2'b10,
        FLAG_Z  = 2'b11
    } alu_flag_e;

    typedef struct packed {
        logic          carry;
        logic [DW-1:0] data;
    } fib_term_t;

    // Carry into the buffer is the overflow/carry flag code only.
    function automatic logic flag_is_carry(input alu_flag_e flag);
        return (flag == FLAG_OC);
    endfunction

endpackage

// File: rtl/fib_fifo_mem.sv
// Register-array storage for the term FIFO: one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module fib_fifo_mem #(
    parameter int W     = 7,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fib_seq_buffer.sv
// First-word-fall-through buffer between the Fibonacci generator and its consumer.
// Holds {carry, term} pairs; in_ready doubles as the generator's step enable.
module fib_seq_buffer
    import fib_pkg::*;
#(
    parameter int DW    = fib_pkg::DW,
    parameter int DEPTH = fib_pkg::DEPTH,
    parameter int AW    = fib_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_carry,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_carry,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf_seen,
    output logic          drop_seen
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_seen_q, ovf_seen_d;
    logic          drop_seen_q, drop_seen_d;

    logic          push;
    logic          pop;
    logic          mem_we;
    logic [DW:0]   mem_wdata;
    logic [DW:0]   mem_rdata;

    // Status comes from the registered occupancy only, so in_ready never
    // depends on out_ready and there is no pass-through path when full.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_seen_d  = ovf_seen_q;
        drop_seen_d = drop_seen_q;
        mem_we      = 1'b0;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            ovf_seen_d  = 1'b0;
            drop_seen_d = 1'b0;
        end else begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (in_carry) begin
                    ovf_seen_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (in_valid && full) begin
                drop_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_seen_q  <= 1'b0;
            drop_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_seen_q  <= ovf_seen_d;
            drop_seen_q <= drop_seen_d;
        end
    end

    assign mem_wdata = {in_carry, in_data};

    fib_fifo_mem #(
        .W     (DW + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign out_carry = mem_rdata[DW];
    assign out_data  = mem_rdata[DW-1:0];
    assign count     = count_q;
    assign ovf_seen  = ovf_seen_q;
    assign drop_seen = drop_seen_q;

endmodule

// File: tb/tb_fib_seq_buffer.sv
// Bench for fib_seq_buffer: directed Fibonacci scenarios plus random traffic,
// each cycle compared against a queue-based model of the buffer.
module tb_fib_seq_buffer;

    localparam int DW    = 6;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_carry;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_carry;
    logic          out_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ovf_seen;
    logic          drop_seen;

    int n_cmp = 0;
    int n_mis = 0;

    logic [DW:0] model_q[$];
    bit          m_ovf;
    bit          m_drop;

    fib_seq_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf_seen  (ovf_seen),
        .drop_seen (drop_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".count"},     32'(count),     32'(sz));
        chk({tag, ".full"},      32'(full),      32'(sz == DEPTH));
        chk({tag, ".empty"},     32'(empty),     32'(sz == 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(sz != DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
        chk({tag, ".ovf_seen"},  32'(ovf_seen),  32'(m_ovf));
        chk({tag, ".drop_seen"}, 32'(drop_seen), 32'(m_drop));
        if (sz != 0) begin
            chk({tag, ".out_data"},  32'(out_data),  32'(model_q[0][DW-1:0]));
            chk({tag, ".out_carry"}, 32'(out_carry), 32'(model_q[0][DW]));
        end
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit c,
                         input bit r, input bit cl);
        in_valid  = v;
        in_data   = d;
        in_carry  = c;
        out_ready = r;
        clr       = cl;
    endtask

    // Advance one clock: update the model from the pre-edge state, then check.
    task automatic cycle(input string tag);
        bit can_push, can_pop;
        if (clr) begin
            model_q.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            can_push = in_valid && (model_q.size() < DEPTH);
            can_pop  = out_ready && (model_q.size() > 0);
            if (in_valid && model_q.size() == DEPTH) m_drop = 1;
            if (can_pop) void'(model_q.pop_front());
            if (can_push) begin
                model_q.push_back({in_carry, in_data});
                if (in_carry) m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf  = 0;
        m_drop = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (model_q.size() == 0) break;
            drive(0, '0, 0, 1, 0);
            cycle(tag);
        end
        chk({tag, ".drained"}, 32'(empty), 32'd1);
    endtask

    initial begin
        int a, b, f;
        logic [DW-1:0] rd;

        drive(0, '0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");
        cycle("idle");

        // Fibonacci 2..34 held back, then drained in order
        a = 1;
        b = 1;
        for (int i = 0; i < 7; i++) begin
            f = (a + b) % 64;
            drive(1, DW'(f), 0, 0, 0);
            cycle("fib_push");
            a = b;
            b = f;
        end
        chk("fib_count7", 32'(count), 32'd7);
        drain("fib_drain");

        // 55 then 89 wrapped to 25 with carry
        f = (a + b) % 64;
        drive(1, DW'(f), 0, 0, 0);
        cycle("fib55");
        a = b;
        b = f;
        f = a + b;
        drive(1, DW'(f % 64), f >= 64, 0, 0);
        cycle("fib25");
        drain("wrap_drain");
        chk("ovf_sticky", 32'(ovf_seen), 32'd1);

        // Fill to full, attempt a 17th, drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, DW'(i), 0, 0, 0);
            cycle("fill");
        end
        chk("full_flag", 32'(full), 32'd1);
        drive(1, 6'd63, 0, 0, 0);
        cycle("drop");
        chk("drop_count", 32'(count), 32'd16);
        drain("full_drain");

        // Simultaneous push/pop at count=1
        drive(1, 6'd5, 0, 0, 0);
        cycle("one_head");
        drive(1, 6'd8, 0, 1, 0);
        cycle("pushpop");
        chk("pushpop_data", 32'(out_data), 32'd8);
        for (int i = 0; i < 40; i++) begin
            drive(1, DW'($urandom), 0, 1, 0);
            cycle("stream");
        end
        drain("stream_drain");

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), DW'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 63) == 0));
            cycle("rand");
        end
        drive(0, '0, 0, 0, 0);
        cycle("rand_end");

        // Async reset mid-cycle with 10 queued terms
        drive(0, '0, 0, 0, 1);
        cycle("pre_rst_clr");
        for (int i = 0; i < 10; i++) begin
            drive(1, DW'(i + 20), (i == 3), 0, 0);
            cycle("load10");
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("post_rst");

        // clr beats push and pop in the same cycle
        drive(1, 6'd7, 1, 0, 0);
        cycle("ovf_set");
        drive(1, 6'd9, 0, 0, 0);
        cycle("second");
        drive(1, 6'd11, 0, 1, 1);
        cycle("clr");
        chk("clr_ovf", 32'(ovf_seen), 32'd0);
        drive(0, '0, 0, 0, 0);
        cycle("after_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
